imem_resp: RTL and testbench
============================

# imem_resp

Instruction-memory responder for the core's fetch path. It accepts word-aligned fetch addresses on a valid/ready request channel, such as the byte address the program counter produces with a +4 step. It returns the 32-bit instruction word on a valid/ready response channel after a programmable number of wait states. It holds one outstanding request and flags misaligned or out-of-range fetches. A side load port lets the bench or boot logic write the program image.

## Interface
- DEPTH_LOG2, 10, log2 of the number of 32-bit words stored (1024 words, byte range 0x0000_0000–0x0000_0FFF)
- WAIT_STATES, 1, extra cycles between request acceptance and response valid (0–15)
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  asynchronous, active-low reset (reset = 0 resets the block)
- req_valid  input  1  fetch request present
- req_ready  output  1  responder can accept a request
- req_addr  input  32  byte address of the fetch
- rsp_valid  output  1  response word present
- rsp_ready  input  1  fetch unit accepts the response
- rsp_data  output  32  instruction word
- rsp_err  output  1  fetch was misaligned or out of range
- ld_en  input  1  write strobe for the load port
- ld_addr  input  DEPTH_LOG2  word index to write
- ld_data  input  32  word to write

## Operation
- FSM states: IDLE, WAIT, RESP. Reset enters IDLE.
- req_ready = (state == IDLE). It is combinational from state only, never from req_valid.
- Accept: req_valid && req_ready on a clk edge. This latches req_addr into an address register and loads the wait counter with WAIT_STATES.
  - If WAIT_STATES = 0: IDLE -> RESP.
  - Otherwise: IDLE -> WAIT.
- WAIT: the counter decrements each cycle. When the counter reaches 1, the FSM goes to RESP on the next edge.
- On entry to RESP, rsp_data and rsp_err are registered from the latched address:
  - misaligned = addr[1:0] != 0
  - out_of_range = addr[31:DEPTH_LOG2+2] != 0
  - rsp_err = misaligned || out_of_range
  - If rsp_err: rsp_data = 0x0000_0000.
  - Otherwise: rsp_data = mem[addr[DEPTH_LOG2+1:2]].
- RESP: rsp_valid = 1, and rsp_data and rsp_err are held stable until rsp_valid && rsp_ready. The FSM then returns to IDLE. No back-to-back acceptance in the same edge: the next request is accepted at the earliest one cycle after the response handshake.
- Load port: ld_en on a clk edge writes ld_data to mem[ld_addr]. Load writes are independent of FSM state.
- Same-edge load and read of the same word (RESP entry edge): the read returns the old word (read-before-write). The new word is visible to later fetches.
- Memory contents are not cleared by reset.

## Timing
- Reset values:
  - state = IDLE, so req_ready = 1 while reset is low.
  - rsp_valid = 0, rsp_data = 0x0000_0000, rsp_err = 0, wait counter = 0.
- Latency from the accept edge to rsp_valid high is WAIT_STATES + 1 cycles (1 cycle when WAIT_STATES = 0).
- Minimum period between accepts is WAIT_STATES + 2 cycles when rsp_ready is held at 1.
- rsp_ready low stalls RESP indefinitely, with outputs frozen.
- req_valid while not ready is ignored. req_addr is sampled only on the accept edge.
- Reset asserted mid-operation (WAIT or RESP) immediately forces IDLE, drops rsp_valid, and discards the pending request. No response is issued after reset releases.
- rsp_ready asserted while rsp_valid = 0 has no effect.
- Address wrap: none. Any address at or above 4·2^DEPTH_LOG2 is out_of_range and never aliases.

## Test plan
- Load mem[0..3] = 0x00000013, 0x00100093, 0x00200113, 0x00308193. With WAIT_STATES = 1 and rsp_ready held at 1, fetch 0x0, 0x4, 0x8, 0xC -> each rsp_valid arrives 2 cycles after accept with the matching word, rsp_err = 0, and accepts are spaced 3 cycles apart.
- Fetch 0x6 -> rsp_err = 1 and rsp_data = 0x00000000. Fetch 0x0000_1000 (DEPTH_LOG2 = 10) -> rsp_err = 1 and rsp_data = 0x00000000.
- Fetch 0x4 with rsp_ready held at 0 for 5 cycles -> rsp_valid = 1 and rsp_data = 0x00100093 stay stable throughout, and req_ready = 0. Raise rsp_ready -> one handshake, then req_ready = 1 on the next cycle.
- With WAIT_STATES = 0, fetch 0x8 -> rsp_valid is high 1 cycle after accept with 0x00200113.
- Drive reset low during WAIT of a fetch to 0xC -> rsp_valid stays 0, state is IDLE, and req_ready = 1. After release, no stale response appears.
- Write ld_addr = 3, ld_data = 0xDEADBEEF on the RESP-entry edge of a fetch to 0xC -> the response is 0x00308193. A following fetch of 0xC returns 0xDEADBEEF.

Source files
------------

// File: rtl/imem_resp_if.sv
// imem_resp_if: fetch request/response channels plus the program-image load port.
interface imem_resp_if #(parameter int DEPTH_LOG2 = 10);
    logic                  req_valid;
    logic                  req_ready;
    logic [31:0]           req_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_data;
    logic                  rsp_err;
    logic                  ld_en;
    logic [DEPTH_LOG2-1:0] ld_addr;
    logic [31:0]           ld_data;
    modport master (
        output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );
    modport slave (
        input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/imem_resp.sv
// imem_resp: single-outstanding instruction fetch responder with programmable wait states,
// misaligned/out-of-range error flagging and a side load port for the program image.
module imem_resp #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input logic         clk,
    input logic         reset,
    imem_resp_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic [31:0] mem [2**DEPTH_LOG2];
    logic [31:0] fetch_addr;
    logic        fetch_err;
    logic [31:0] rd_word;
    // With zero wait states RESP is entered on the accept edge, so the address comes straight from the bus.
    assign fetch_addr = (state_q == IDLE) ? bus.req_addr : addr_q;
    assign fetch_err  = (|fetch_addr[1:0]) || (|fetch_addr[31:DEPTH_LOG2+2]);
    assign rd_word    = mem[fetch_addr[DEPTH_LOG2+1:2]];
    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: if (bus.req_valid) begin
                addr_d  = bus.req_addr;
                cnt_d   = 4'(WAIT_STATES);
                state_d = (WAIT_STATES == 0) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? RESP : WAIT;
            end
            RESP: state_d = bus.rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        if (state_d == RESP && state_q != RESP) begin
            err_d  = fetch_err;
            data_d = fetch_err ? 32'h0 : rd_word;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end
    // Nonblocking write keeps a same-edge fetch on the old word.
    always_ff @(posedge clk) begin
        if (bus.ld_en) mem[bus.ld_addr] <= bus.ld_data;
    end
endmodule

// File: tb/tb_imem_resp.sv
// tb_imem_resp: table-driven fetch vectors plus directed stall, reset, zero-wait and load-collision sequences.
module tb_imem_resp;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_resp_if #(.DEPTH_LOG2(10)) b1 ();
    imem_resp_if #(.DEPTH_LOG2(10)) b0 ();
    imem_resp #(.DEPTH_LOG2(10), .WAIT_STATES(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
    imem_resp #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic load(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        b1.ld_en = 1'b1; b1.ld_addr = a; b1.ld_data = d;
        b0.ld_en = 1'b1; b0.ld_addr = a; b0.ld_data = d;
        @(posedge clk);
        #1 b1.ld_en = 1'b0; b0.ld_en = 1'b0;
    endtask

    task automatic accept(input logic [31:0] a, output int stamp);
        @(negedge clk);
        chk("req_ready_before_accept", 32'(b1.req_ready), 32'd1);
        b1.req_valid = 1'b1; b1.req_addr = a;
        @(posedge clk);
        #1 stamp = cyc;
        b1.req_valid = 1'b0; b1.req_addr = 32'hFFFF_FFFF;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!b1.rsp_valid && lat < 20);
        if (!b1.rsp_valid) chk("rsp_timeout", 32'(b1.rsp_valid), 32'd1);
    endtask

    initial begin
        int lat, stamp, prev;
        logic stray, stable;
        vecs[0] = '{32'h0000_0000, 32'h0000_0013, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'h0010_0093, 1'b0};
        vecs[2] = '{32'h0000_0008, 32'h0020_0113, 1'b0};
        vecs[3] = '{32'h0000_000C, 32'h0030_8193, 1'b0};
        vecs[4] = '{32'h0000_0006, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'h0000_1000, 32'h0000_0000, 1'b1};
        vecs[6] = '{32'h0000_0FFC, 32'hCAFE_F00D, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h0000_0000, 1'b1};
        vecs[8] = '{32'h0000_0002, 32'h0000_0000, 1'b1};
        b1.req_valid = 1'b0; b1.req_addr = '0; b1.rsp_ready = 1'b1;
        b1.ld_en = 1'b0; b1.ld_addr = '0; b1.ld_data = '0;
        b0.req_valid = 1'b0; b0.req_addr = '0; b0.rsp_ready = 1'b1;
        b0.ld_en = 1'b0; b0.ld_addr = '0; b0.ld_data = '0;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", 32'(b1.req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(b1.rsp_valid), 32'd0);
        chk("reset_rsp_data", b1.rsp_data, 32'h0);
        chk("reset_rsp_err", 32'(b1.rsp_err), 32'd0);
        reset = 1'b1;
        load(10'd0, 32'h0000_0013);
        load(10'd1, 32'h0010_0093);
        load(10'd2, 32'h0020_0113);
        load(10'd3, 32'h0030_8193);
        load(10'd1023, 32'hCAFE_F00D);
        prev = 0;
        for (int i = 0; i < 9; i++) begin
            accept(vecs[i].addr, stamp);
            if (i > 0) chk($sformatf("accept_spacing[%0d]", i), 32'(stamp - prev), 32'd3);
            prev = stamp;
            wait_rsp(lat);
            chk($sformatf("latency[%0d]", i), 32'(lat), 32'd2);
            chk($sformatf("rsp_data[%0d]", i), b1.rsp_data, vecs[i].data);
            chk($sformatf("rsp_err[%0d]", i), 32'(b1.rsp_err), 32'(vecs[i].err));
        end
        // Back-pressure: response must hold while rsp_ready is low
        @(negedge clk);
        b1.rsp_ready = 1'b0;
        accept(32'h4, stamp);
        wait_rsp(lat);
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (b1.rsp_valid !== 1'b1 || b1.rsp_data !== 32'h0010_0093 || b1.req_ready !== 1'b0) stable = 1'b0;
        end
        chk("stall_stable", 32'(stable), 32'd1);
        b1.rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_rsp_valid", 32'(b1.rsp_valid), 32'd0);
        chk("stall_release_req_ready", 32'(b1.req_ready), 32'd1);
        // Zero wait states
        @(negedge clk);
        b0.req_valid = 1'b1; b0.req_addr = 32'h8;
        @(posedge clk);
        #1 b0.req_valid = 1'b0;
        @(negedge clk);
        chk("ws0_rsp_valid", 32'(b0.rsp_valid), 32'd1);
        chk("ws0_rsp_data", b0.rsp_data, 32'h0020_0113);
        chk("ws0_rsp_err", 32'(b0.rsp_err), 32'd0);
        @(negedge clk);
        chk("ws0_req_ready_after", 32'(b0.req_ready), 32'd1);
        // Reset during WAIT
        accept(32'hC, stamp);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_rsp_valid", 32'(b1.rsp_valid), 32'd0);
        chk("midreset_req_ready", 32'(b1.req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        stray = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (b1.rsp_valid !== 1'b0) stray = 1'b1;
        end
        chk("midreset_no_stale_rsp", 32'(stray), 32'd0);
        // Load on the RESP-entry edge returns the old word
        accept(32'hC, stamp);
        b1.ld_en = 1'b1; b1.ld_addr = 10'd3; b1.ld_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 b1.ld_en = 1'b0;
        wait_rsp(lat);
        chk("collide_old_word", b1.rsp_data, 32'h0030_8193);
        accept(32'hC, stamp);
        wait_rsp(lat);
        chk("collide_new_word", b1.rsp_data, 32'hDEAD_BEEF);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
